// File: rtl/lfsr_checker.sv
// Receive-side checker for the 8-bit LFSR stream (s7^s5^s4^s3 feedback).
// It self-synchronises to the incoming words, flywheels once locked, and counts word errors.
module lfsr_checker #(
  parameter int LOCK_COUNT  = 4,
  parameter int UNLOCK_ERRS = 3,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [7:0]       data,
  input  logic             clear_errs,
  output logic             locked,
  output logic             err_pulse,
  output logic             sync_lost,
  output logic [ERR_W-1:0] err_count
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_ERRS + 1);
  localparam logic [MW-1:0]    LOCK_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [BW-1:0]    BAD_LAST  = BW'(UNLOCK_ERRS - 1);
  localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  state_e           state_q, state_d;
  logic [7:0]       exp_q, exp_d;
  logic [MW-1:0]    match_q, match_d;
  logic [BW-1:0]    bad_q, bad_d;
  logic             locked_q, locked_d;
  logic             err_pulse_q, err_pulse_d;
  logic             sync_lost_q, sync_lost_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             err_hit;

  // Next-state, prediction and error accounting
  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    match_d     = match_q;
    bad_d       = bad_q;
    locked_d    = locked_q;
    err_pulse_d = 1'b0;
    sync_lost_d = 1'b0;
    err_hit     = 1'b0;
    if (valid) begin
      case (state_q)
        SEARCH: begin
          if (data != 8'h00) begin
            exp_d   = lfsr_next(data);
            match_d = '0;
            state_d = VERIFY;
          end else begin
            state_d = SEARCH;
          end
        end
        VERIFY: begin
          if (data == exp_q) begin
            exp_d   = lfsr_next(data);
            match_d = match_q + 1'b1;
            if (match_q == LOCK_LAST) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              bad_d    = '0;
            end else begin
              state_d = VERIFY;
            end
          end else if (data != 8'h00) begin
            exp_d   = lfsr_next(data);
            match_d = '0;
          end else begin
            state_d = SEARCH;
            match_d = '0;
          end
        end
        LOCKED: begin
          // Flywheel: prediction advances from our own state, never from data
          exp_d = lfsr_next(exp_q);
          if (data == exp_q) begin
            bad_d = '0;
          end else begin
            err_hit     = 1'b1;
            err_pulse_d = 1'b1;
            bad_d       = bad_q + 1'b1;
            if (bad_q == BAD_LAST) begin
              state_d     = SEARCH;
              locked_d    = 1'b0;
              sync_lost_d = 1'b1;
              bad_d       = '0;
              match_d     = '0;
            end else begin
              state_d = LOCKED;
            end
          end
        end
        default: begin
          state_d  = SEARCH;
          locked_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // A clear coinciding with an error keeps that error
    if (clear_errs) begin
      err_count_d = err_hit ? ERR_ONE : '0;
    end else if (err_hit && (err_count_q != ERR_MAX)) begin
      err_count_d = err_count_q + ERR_ONE;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SEARCH;
      exp_q       <= 8'h00;
      match_q     <= '0;
      bad_q       <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      sync_lost_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      match_q     <= match_d;
      bad_q       <= bad_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      sync_lost_q <= sync_lost_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign sync_lost = sync_lost_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: default instance plus a 2-bit-count instance
// with a long unlock run for the saturation and clear scenarios.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        clear_errs = 1'b0;
  logic        locked, err_pulse, sync_lost;
  logic [15:0] err_count;
  logic        locked2, err_pulse2, sync_lost2;
  logic [1:0]  err_count2;

  int errors = 0;
  int checks = 0;

  lfsr_checker #(.LOCK_COUNT(4), .UNLOCK_ERRS(3), .ERR_W(16)) dut (
    .clk(clk), .reset(reset), .valid(valid), .data(data), .clear_errs(clear_errs),
    .locked(locked), .err_pulse(err_pulse), .sync_lost(sync_lost), .err_count(err_count)
  );

  lfsr_checker #(.LOCK_COUNT(4), .UNLOCK_ERRS(8), .ERR_W(2)) dut2 (
    .clk(clk), .reset(reset), .valid(valid), .data(data), .clear_errs(clear_errs),
    .locked(locked2), .err_pulse(err_pulse2), .sync_lost(sync_lost2), .err_count(err_count2)
  );

  always #5 clk = ~clk;

  task automatic step(input logic v, input logic [7:0] d, input logic c);
    valid = v; data = d; clear_errs = c;
    @(posedge clk); #1;
    valid = 1'b0; clear_errs = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic lock_seq();
    logic [7:0] seq [5];
    seq = '{8'hAA, 8'h55, 8'hAB, 8'h57, 8'hAF};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, seq[i], 1'b0);
      checks++;
      if (locked !== (i == 4)) begin
        errors++; $display("FAIL lock_seq[%0d]: locked=%b want %b", i, locked, (i == 4));
      end
      checks++;
      if (err_pulse !== 1'b0) begin
        errors++; $display("FAIL lock_seq_pulse[%0d]: err_pulse=%b want 0", i, err_pulse);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({locked, err_pulse, sync_lost} !== 3'b000 || err_count !== 16'd0 || err_count2 !== 2'd0) begin
      errors++; $display("FAIL reset: l=%b p=%b s=%b cnt=%0d cnt2=%0d want all 0",
                         locked, err_pulse, sync_lost, err_count, err_count2);
    end
  endtask

  task automatic test_lock();
    lock_seq();
    checks++;
    if (err_count !== 16'd0) begin
      errors++; $display("FAIL lock_count: err_count=%0d want 0", err_count);
    end
  endtask

  task automatic test_single_error();
    step(1'b1, 8'h00, 1'b0);  // expected 5F
    checks++;
    if (err_pulse !== 1'b1 || err_count !== 16'd1 || locked !== 1'b1) begin
      errors++; $display("FAIL single_err: p=%b cnt=%0d l=%b want 1,1,1", err_pulse, err_count, locked);
    end
    step(1'b1, 8'hBE, 1'b0);
    checks++;
    if (err_pulse !== 1'b0 || err_count !== 16'd1 || locked !== 1'b1) begin
      errors++; $display("FAIL single_flywheel: p=%b cnt=%0d l=%b want 0,1,1", err_pulse, err_count, locked);
    end
    step(1'b1, 8'h7C, 1'b0);
    step(1'b1, 8'hF9, 1'b0);
    checks++;
    if (err_pulse !== 1'b0 || err_count !== 16'd1 || sync_lost !== 1'b0) begin
      errors++; $display("FAIL single_follow: p=%b cnt=%0d s=%b want 0,1,0", err_pulse, err_count, sync_lost);
    end
  endtask

  task automatic test_loss_of_lock();
    logic [7:0] seq [5];
    // Predictions are F2, E5, CA; send three words that match none
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 8'(i), 1'b0);
      checks++;
      if (err_pulse !== 1'b1 || sync_lost !== (i == 3) || locked !== (i != 3)) begin
        errors++; $display("FAIL loss[%0d]: p=%b s=%b l=%b want 1,%b,%b",
                           i, err_pulse, sync_lost, locked, (i == 3), (i != 3));
      end
    end
    checks++;
    if (err_count !== 16'd4) begin
      errors++; $display("FAIL loss_count: err_count=%0d want 4", err_count);
    end
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if (err_pulse !== 1'b0 || sync_lost !== 1'b0 || locked !== 1'b0) begin
      errors++; $display("FAIL loss_idle: p=%b s=%b l=%b want 0,0,0", err_pulse, sync_lost, locked);
    end
    // Relock with a valid gap in the middle
    seq = '{8'hAA, 8'h55, 8'hAB, 8'h57, 8'hAF};
    for (int i = 0; i < 5; i++) begin
      if (i == 2) step(1'b0, 8'h00, 1'b0);
      step(1'b1, seq[i], 1'b0);
      checks++;
      if (locked !== (i == 4)) begin
        errors++; $display("FAIL relock[%0d]: locked=%b want %b", i, locked, (i == 4));
      end
    end
    checks++;
    if (err_count !== 16'd4) begin
      errors++; $display("FAIL relock_count: err_count=%0d want 4", err_count);
    end
  endtask

  task automatic test_zero_reseed();
    logic [7:0] seq [7];
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 8'h00, 1'b0);
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL zero_search: locked=%b want 0", locked);
    end
    // 13 breaks the AA chain and reseeds; 27,4F,9F,3F are its successors
    seq = '{8'hAA, 8'h55, 8'h13, 8'h27, 8'h4F, 8'h9F, 8'h3F};
    for (int i = 0; i < 7; i++) begin
      step(1'b1, seq[i], 1'b0);
      checks++;
      if (locked !== (i == 6)) begin
        errors++; $display("FAIL reseed[%0d]: locked=%b want %b", i, locked, (i == 6));
      end
    end
    checks++;
    if (err_count !== 16'd0) begin
      errors++; $display("FAIL reseed_count: err_count=%0d want 0", err_count);
    end
  endtask

  task automatic test_saturation_clear();
    logic [1:0] want [5];
    want = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    lock_seq();
    // Predictions 5F,BE,7C,F9,F2; send 01..05
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'(i + 1), 1'b0);
      checks++;
      if (err_count2 !== want[i] || locked2 !== 1'b1 || err_pulse2 !== 1'b1) begin
        errors++; $display("FAIL sat[%0d]: cnt2=%0d l2=%b p2=%b want %0d,1,1",
                           i, err_count2, locked2, err_pulse2, want[i]);
      end
    end
    step(1'b1, 8'h06, 1'b1);  // prediction E5: error with clear
    checks++;
    if (err_count2 !== 2'd1 || sync_lost2 !== 1'b0 || locked2 !== 1'b1) begin
      errors++; $display("FAIL clear_err: cnt2=%0d s2=%b l2=%b want 1,0,1", err_count2, sync_lost2, locked2);
    end
    step(1'b1, 8'hCA, 1'b1);  // matching word with clear
    checks++;
    if (err_count2 !== 2'd0 || err_pulse2 !== 1'b0 || err_count !== 16'd0) begin
      errors++; $display("FAIL clear_ok: cnt2=%0d p2=%b cnt=%0d want 0,0,0", err_count2, err_pulse2, err_count);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    lock_seq();
    step(1'b1, 8'h00, 1'b0);
    checks++;
    if (err_count !== 16'd1 || err_pulse !== 1'b1) begin
      errors++; $display("FAIL pre_reset: cnt=%0d p=%b want 1,1", err_count, err_pulse);
    end
    reset = 1'b0;
    #2;
    checks++;
    if (locked !== 1'b0 || err_pulse !== 1'b0 || sync_lost !== 1'b0 || err_count !== 16'd0) begin
      errors++; $display("FAIL async_reset: l=%b p=%b s=%b cnt=%0d want 0", locked, err_pulse, sync_lost, err_count);
    end
    reset = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if (locked !== 1'b0 || err_pulse !== 1'b0 || sync_lost !== 1'b0 || err_count !== 16'd0) begin
      errors++; $display("FAIL post_reset: l=%b p=%b s=%b cnt=%0d want 0", locked, err_pulse, sync_lost, err_count);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_single_error();
    test_loss_of_lock();
    test_zero_reseed();
    test_saturation_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
